// File: rtl/float_type.sv
// Shared floating-point classification type used by the decode and pipeline blocks.
package float_type;

    typedef enum logic [2:0] {
        ZERO              = 3'd0,
        denormalized      = 3'd1,
        normalized        = 3'd2,
        positive_infinity = 3'd3,
        negative_infinity = 3'd4,
        NaN               = 3'd5
    } type_of_float;

endpackage

// File: rtl/float_class_decode.sv
// Combinational classifier: packed float fields -> class, hidden mantissa bit, unbiased exponent.
module float_class_decode
    import float_type::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                    sign_i,
    input  logic [EXP_W-1:0]        exp_i,
    input  logic [MAN_W-1:0]        frac_i,
    output type_of_float            form_o,
    output logic                    hidden_o,
    output logic signed [EXP_W+1:0] unb_exp_o
);

    localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int DEN_EXP = 1 - BIAS;
    localparam logic [EXP_W+1:0] BIAS_V    = BIAS[EXP_W+1:0];
    localparam logic [EXP_W+1:0] DEN_EXP_V = DEN_EXP[EXP_W+1:0];

    logic [EXP_W+1:0] exp_ext_s;
    logic             frac_zero_s;

    assign exp_ext_s   = {2'b00, exp_i};
    assign frac_zero_s = (frac_i == {MAN_W{1'b0}});

    // Class decode; subnormals share the minimum normal exponent
    always_comb begin
        form_o    = ZERO;
        hidden_o  = 1'b0;
        unb_exp_o = DEN_EXP_V;
        if (exp_i == {EXP_W{1'b0}}) begin
            if (frac_zero_s) begin
                form_o = ZERO;
            end else begin
                form_o = denormalized;
            end
        end else if (&exp_i) begin
            unb_exp_o = {(EXP_W+2){1'b0}};
            if (!frac_zero_s) begin
                form_o = NaN;
            end else if (sign_i) begin
                form_o = negative_infinity;
            end else begin
                form_o = positive_infinity;
            end
        end else begin
            form_o    = normalized;
            hidden_o  = 1'b1;
            unb_exp_o = exp_ext_s - BIAS_V;
        end
    end

endmodule

// File: rtl/float_classify_pipe.sv
// Two-stage valid/ready float classification pipeline.
// Optional per-class statistics counters are built when FLOAT_CLASS_STATS_EN is defined.
module float_classify_pipe
    import float_type::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 16,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic [EXP_W-1:0]        out_exponent,
    output logic [MAN_W:0]          out_mantissa,
    output logic signed [EXP_W+1:0] out_unb_exp,
    output type_of_float            out_form
`ifdef FLOAT_CLASS_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [CNT_W-1:0]        cnt_norm,
    output logic [CNT_W-1:0]        cnt_denorm,
    output logic [CNT_W-1:0]        cnt_zero,
    output logic [CNT_W-1:0]        cnt_inf,
    output logic [CNT_W-1:0]        cnt_nan
`endif
);

    logic                    s1_valid_q, s1_valid_d;
    logic [W-1:0]            s1_data_q, s1_data_d;
    logic                    s2_valid_q, s2_valid_d;
    logic                    s2_sign_q, s2_sign_d;
    logic [EXP_W-1:0]        s2_exp_q, s2_exp_d;
    logic [MAN_W:0]          s2_man_q, s2_man_d;
    logic signed [EXP_W+1:0] s2_unb_q, s2_unb_d;
    type_of_float            s2_form_q, s2_form_d;

    logic                    s2_load_s;
    logic                    dec_hidden_s;
    logic signed [EXP_W+1:0] dec_unb_s;
    type_of_float            dec_form_s;

    float_class_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_decode (
        .sign_i    (s1_data_q[W-1]),
        .exp_i     (s1_data_q[W-2:MAN_W]),
        .frac_i    (s1_data_q[MAN_W-1:0]),
        .form_o    (dec_form_s),
        .hidden_o  (dec_hidden_s),
        .unb_exp_o (dec_unb_s)
    );

    // S2 may load when empty or emptying; in_ready depends only on state and out_ready
    assign s2_load_s = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_load_s;

    // Next-state for both stages
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_exp_d   = s2_exp_q;
        s2_man_d   = s2_man_q;
        s2_unb_d   = s2_unb_q;
        s2_form_d  = s2_form_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
            end else begin
                s1_data_d = s1_data_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_load_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_d = s1_data_q[W-1];
                s2_exp_d  = s1_data_q[W-2:MAN_W];
                s2_man_d  = {dec_hidden_s, s1_data_q[MAN_W-1:0]};
                s2_unb_d  = dec_unb_s;
                s2_form_d = dec_form_s;
            end else begin
                s2_form_d = s2_form_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= {W{1'b0}};
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= {EXP_W{1'b0}};
            s2_man_q   <= {(MAN_W+1){1'b0}};
            s2_unb_q   <= {(EXP_W+2){1'b0}};
            s2_form_q  <= ZERO;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_exp_q   <= s2_exp_d;
            s2_man_q   <= s2_man_d;
            s2_unb_q   <= s2_unb_d;
            s2_form_q  <= s2_form_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_sign     = s2_sign_q;
    assign out_exponent = s2_exp_q;
    assign out_mantissa = s2_man_q;
    assign out_unb_exp  = s2_unb_q;
    assign out_form     = s2_form_q;

`ifdef FLOAT_CLASS_STATS_EN
    logic [CNT_W-1:0] norm_q, norm_d, denorm_q, denorm_d, zero_q, zero_d;
    logic [CNT_W-1:0] inf_q, inf_d, nan_q, nan_d;
    logic             out_xfer_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign out_xfer_s = s2_valid_q && out_ready;

    // Counter next-state; clear wins over a same-cycle increment
    always_comb begin
        norm_d   = norm_q;
        denorm_d = denorm_q;
        zero_d   = zero_q;
        inf_d    = inf_q;
        nan_d    = nan_q;
        if (stats_clr) begin
            norm_d   = {CNT_W{1'b0}};
            denorm_d = {CNT_W{1'b0}};
            zero_d   = {CNT_W{1'b0}};
            inf_d    = {CNT_W{1'b0}};
            nan_d    = {CNT_W{1'b0}};
        end else if (out_xfer_s) begin
            case (s2_form_q)
                normalized:        norm_d   = sat_inc(norm_q);
                denormalized:      denorm_d = sat_inc(denorm_q);
                ZERO:              zero_d   = sat_inc(zero_q);
                positive_infinity,
                negative_infinity: inf_d    = sat_inc(inf_q);
                NaN:               nan_d    = sat_inc(nan_q);
                default:           norm_d   = norm_q;
            endcase
        end else begin
            norm_d = norm_q;
        end
    end

    // Statistics counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            norm_q   <= {CNT_W{1'b0}};
            denorm_q <= {CNT_W{1'b0}};
            zero_q   <= {CNT_W{1'b0}};
            inf_q    <= {CNT_W{1'b0}};
            nan_q    <= {CNT_W{1'b0}};
        end else begin
            norm_q   <= norm_d;
            denorm_q <= denorm_d;
            zero_q   <= zero_d;
            inf_q    <= inf_d;
            nan_q    <= nan_d;
        end
    end

    assign cnt_norm   = norm_q;
    assign cnt_denorm = denorm_q;
    assign cnt_zero   = zero_q;
    assign cnt_inf    = inf_q;
    assign cnt_nan    = nan_q;
`endif

endmodule

// File: tb/tb_float_classify_pipe.sv
// Directed self-checking bench for float_classify_pipe (default and half-precision instances).
// Statistics checks are compiled when FLOAT_CLASS_STATS_EN is defined.
module tb_float_classify_pipe;
    import float_type::*;

    logic clk;
    logic rst;

    logic               in_valid, in_ready, out_valid, out_ready, out_sign;
    logic [31:0]        in_data;
    logic [7:0]         out_exponent;
    logic [23:0]        out_mantissa;
    logic signed [9:0]  out_unb_exp;
    type_of_float       out_form;

    logic               s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sign;
    logic [15:0]        s_in_data;
    logic [4:0]         s_out_exponent;
    logic [10:0]        s_out_mantissa;
    logic signed [6:0]  s_out_unb_exp;
    type_of_float       s_out_form;

`ifdef FLOAT_CLASS_STATS_EN
    logic        stats_clr;
    logic [15:0] cnt_norm, cnt_denorm, cnt_zero, cnt_inf, cnt_nan;
    logic [1:0]  s_cnt_norm, s_cnt_denorm, s_cnt_zero, s_cnt_inf, s_cnt_nan;
`endif

    int checks = 0;
    int errors = 0;

    float_classify_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_exponent(out_exponent), .out_mantissa(out_mantissa),
        .out_unb_exp(out_unb_exp), .out_form(out_form)
`ifdef FLOAT_CLASS_STATS_EN
        , .stats_clr(stats_clr), .cnt_norm(cnt_norm), .cnt_denorm(cnt_denorm),
        .cnt_zero(cnt_zero), .cnt_inf(cnt_inf), .cnt_nan(cnt_nan)
`endif
    );

    float_classify_pipe #(.EXP_W(5), .MAN_W(10), .CNT_W(2)) dut_half (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sign(s_out_sign),
        .out_exponent(s_out_exponent), .out_mantissa(s_out_mantissa),
        .out_unb_exp(s_out_unb_exp), .out_form(s_out_form)
`ifdef FLOAT_CLASS_STATS_EN
        , .stats_clr(stats_clr), .cnt_norm(s_cnt_norm), .cnt_denorm(s_cnt_denorm),
        .cnt_zero(s_cnt_zero), .cnt_inf(s_cnt_inf), .cnt_nan(s_cnt_nan)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic sgn, input logic [7:0] e,
                             input logic [23:0] m, input int unb, input type_of_float f);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".sign"}, out_sign, sgn);
        check({tag, ".exp"}, out_exponent, e);
        check({tag, ".man"}, out_mantissa, m);
        check({tag, ".unb"}, out_unb_exp, unb);
        check({tag, ".form"}, out_form, f);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = 16'h0; s_out_ready = 1'b1;
`ifdef FLOAT_CLASS_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) nxt();
        check("rst.valid", out_valid, 1'b0);
        check("rst.form", out_form, ZERO);
        check("rst.man", out_mantissa, 24'h0);
        check("rst.unb", out_unb_exp, 0);
        rst = 1'b0;
        check("rst.in_ready", in_ready, 1'b1);

        // 1.0: two-cycle latency
        in_valid = 1'b1; in_data = 32'h3F800000;
        nxt();
        in_valid = 1'b0;
        check("one.early", out_valid, 1'b0);
        nxt();
        check_out("one", 1'b0, 8'h7F, 24'h800000, 0, normalized);
        nxt();
        check("one.drain", out_valid, 1'b0);

        // smallest denormal then -0, back to back
        in_valid = 1'b1; in_data = 32'h00000001;
        nxt();
        in_data = 32'h80000000;
        nxt();
        in_valid = 1'b0;
        check_out("den", 1'b0, 8'h00, 24'h000001, -126, denormalized);
        nxt();
        check_out("nzero", 1'b1, 8'h00, 24'h000000, -126, ZERO);
        nxt();
        check("den.drain", out_valid, 1'b0);

        // +inf, -inf, qNaN
        in_valid = 1'b1; in_data = 32'h7F800000;
        nxt();
        in_data = 32'hFF800000;
        nxt();
        in_data = 32'h7FC00000;
        check_out("pinf", 1'b0, 8'hFF, 24'h000000, 0, positive_infinity);
        nxt();
        in_valid = 1'b0;
        check_out("ninf", 1'b1, 8'hFF, 24'h000000, 0, negative_infinity);
        nxt();
        check_out("nan", 1'b0, 8'hFF, 24'h400000, 0, NaN);
`ifdef FLOAT_CLASS_STATS_EN
        check("cnt_inf", cnt_inf, 16'd2);
`endif
        nxt();
        check("nan.drain", out_valid, 1'b0);
`ifdef FLOAT_CLASS_STATS_EN
        check("cnt_nan", cnt_nan, 16'd1);
        check("cnt_norm1", cnt_norm, 16'd1);
        check("cnt_denorm", cnt_denorm, 16'd1);
        check("cnt_zero", cnt_zero, 16'd1);
`endif

        // backpressure: 2.0, -3.0, 0.5 with consumer stalled 5 cycles
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h40000000;
        nxt();
        check("bp.ready1", in_ready, 1'b1);
        in_data = 32'hC0400000;
        nxt();
        in_data = 32'h3F000000;
        for (int i = 0; i < 4; i++) begin
            check("bp.in_ready", in_ready, 1'b0);
            check_out("bp.hold", 1'b0, 8'h80, 24'h800000, 1, normalized);
            if (i < 3) nxt();
        end
        out_ready = 1'b1;
        nxt();
        in_valid = 1'b0;
        check_out("bp.b", 1'b1, 8'h80, 24'hC00000, 1, normalized);
        nxt();
        check_out("bp.c", 1'b0, 8'h7E, 24'h800000, -1, normalized);
        nxt();
        check("bp.drain", out_valid, 1'b0);
`ifdef FLOAT_CLASS_STATS_EN
        check("cnt_norm4", cnt_norm, 16'd4);

        // clear collides with a ZERO output transfer
        in_valid = 1'b1; in_data = 32'h00000000;
        nxt();
        in_valid = 1'b0;
        nxt();
        check("clr.valid", out_valid, 1'b1);
        stats_clr = 1'b1;
        nxt();
        stats_clr = 1'b0;
        check("clr.zero", cnt_zero, 16'd0);
        check("clr.norm", cnt_norm, 16'd0);
        check("clr.inf", cnt_inf, 16'd0);
        check("clr.nan", cnt_nan, 16'd0);
        check("clr.denorm", cnt_denorm, 16'd0);
        in_valid = 1'b1; in_data = 32'h3F800000;
        nxt();
        in_valid = 1'b0;
        repeat (2) nxt();
        check("clr.recount", cnt_norm, 16'd1);
`endif

        // half precision instance
        s_in_valid = 1'b1; s_in_data = 16'h3C00;
        nxt();
        s_in_data = 16'h7C00;
        nxt();
        s_in_data = 16'h3C00;
        check("h1.valid", s_out_valid, 1'b1);
        check("h1.form", s_out_form, normalized);
        check("h1.unb", s_out_unb_exp, 0);
        check("h1.man", s_out_mantissa, 11'h400);
        check("h1.exp", s_out_exponent, 5'h0F);
        nxt();
        check("h2.form", s_out_form, positive_infinity);
        check("h2.unb", s_out_unb_exp, 0);
        check("h2.man", s_out_mantissa, 11'h000);
        repeat (3) nxt();
        s_in_valid = 1'b0;
        repeat (4) nxt();
        check("h.drain", s_out_valid, 1'b0);
`ifdef FLOAT_CLASS_STATS_EN
        check("h.cnt_norm_sat", s_cnt_norm, 2'd3);
        check("h.cnt_inf", s_cnt_inf, 2'd1);
`endif

        // reset with two words in flight
        in_valid = 1'b1; in_data = 32'h3F800000;
        nxt();
        in_data = 32'h40000000;
        nxt();
        in_valid = 1'b0;
        check("mid.inflight", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid.valid", out_valid, 1'b0);
        check("mid.form", out_form, ZERO);
`ifdef FLOAT_CLASS_STATS_EN
        check("mid.cnt_norm", cnt_norm, 16'd0);
        check("mid.s_cnt_norm", s_cnt_norm, 2'd0);
`endif
        nxt();
        rst = 1'b0;
        check("mid.in_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            nxt();
            check("mid.stale", out_valid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
